// File: rtl/serial_bit_feeder_if.sv
// Word-in / bit-out signal bundle for serial_bit_feeder.
// Handshake: a word transfers on a rising edge where din_valid && din_ready; din is held stable while din_valid && !din_ready.
interface serial_bit_feeder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             a_out;
    logic             bit_valid;
    logic             word_done;
    logic             busy;
    logic             dbg_shifting;

    modport slave (
        input  din, din_valid,
        output din_ready, a_out, bit_valid, word_done, busy, dbg_shifting
    );

    modport master (
        output din, din_valid,
        input  din_ready, a_out, bit_valid, word_done, busy, dbg_shifting
    );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: one hold register behind a shift register so words stream
// one bit per clock with no gap between back-to-back words.
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    serial_bit_feeder_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic             last_bit;
    logic             load;
    logic [WIDTH-1:0] shifted;
    logic             cur_bit;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        load        = 1'b0;

        accept   = bus.din_valid && bus.din_ready;
        last_bit = (state_q == S_SHIFT) && (cnt_q == CW'(WIDTH - 1));
        shifted  = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            S_SHIFT: begin
                shreg_d = shifted;
                if (last_bit) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            shreg_d     = hold_q;
            cnt_d       = '0;
            hold_full_d = 1'b0;
            state_d     = S_SHIFT;
        end

        // accept requires an empty hold and load requires a full one, so they never collide
        if (accept) begin
            hold_d      = bus.din;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cur_bit          = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign bus.din_ready    = !hold_full_q && !rst;
    assign bus.bit_valid    = (state_q == S_SHIFT);
    assign bus.a_out        = (state_q == S_SHIFT) ? cur_bit : IDLE_BIT;
    assign bus.word_done    = last_bit;
    assign bus.busy         = (state_q == S_SHIFT) || hold_full_q;
    assign bus.dbg_shifting = (state_q == S_SHIFT);
endmodule
